// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_pkg
//  Description : Shared types for the counter command sequencer: command
//                opcodes and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } op_e;

    // Sequencer FSM states
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_cmd_sequencer_if
//  Description : valid/ready command port of the counter command sequencer.
//                master = command producer, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_cmd_sequencer_if #(
    parameter int CNT_W = 8
);
    import counter_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [CNT_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);

endinterface

`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : Synchronous FIFO of DEPTH entries of type T. Pushes into a
//                full FIFO and pops from an empty FIFO are ignored.
//                dout shows the head entry whenever empty is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int C_ADDR_W = $clog2(DEPTH);
    localparam logic [C_ADDR_W:0] C_PTR_ONE = {{C_ADDR_W{1'b0}}, 1'b1};

    T                  r_mem [DEPTH];
    logic [C_ADDR_W:0] r_wr_ptr;
    logic [C_ADDR_W:0] r_rd_ptr;

    // Extra pointer MSB tells full from empty when the addresses match
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[C_ADDR_W] != r_rd_ptr[C_ADDR_W]) &&
                   (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);
    assign dout  = r_mem[r_rd_ptr[C_ADDR_W-1:0]];

    // Pointer update; only the pointers need a reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full)  r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (pop  && !empty) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wr_ptr[C_ADDR_W-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : counter_cmd_sequencer
//  Description : Buffers counter commands in a FIFO and replays each one as
//                cycle-accurate load_n/ce/up_down/data_load controls.
//                Optional macro CNT_SEQ_NOWRAP_EN: gate ce with the counter's
//                max_count/zero feedback so the count saturates; a blocked
//                UP/DOWN command ends that cycle with done and clipped high.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    counter_cmd_sequencer_if.slave   cmd,
    input  logic                     max_count,
    input  logic                     zero,
    output logic                     load_n,
    output logic                     ce,
    output logic                     up_down,
    output logic [WIDTH-1:0]         data_load,
    output logic                     busy,
    output logic                     done,
    output logic                     clipped
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        op_e              op;
        logic [CNT_W-1:0] arg;
    } cmd_t;

    cmd_t             w_fifo_din;
    cmd_t             w_fifo_dout;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_last;
    logic             w_clip;
    logic             w_arg_zero;

    state_e           r_state;
    logic [CNT_W-1:0] r_remain;     // cycles left after the current one
    logic             r_load_n;
    logic             r_ce_q;
    logic             r_up_down;
    logic             r_done;
    logic [WIDTH-1:0] r_data_load;

    assign w_fifo_din.op  = cmd.cmd_op;
    assign w_fifo_din.arg = cmd.cmd_arg;
    assign cmd.cmd_ready  = ~w_full;
    assign w_push         = cmd.cmd_valid & ~w_full;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef CNT_SEQ_NOWRAP_EN
    // Counter sits on the boundary it is about to cross: block the step
    assign w_clip = r_ce_q & (r_up_down ? max_count : zero);
`else
    logic w_unused_fb;
    assign w_unused_fb = max_count ^ zero;
    assign w_clip      = 1'b0;
`endif

    // A command ends on its scheduled last cycle or when clipped early
    assign w_last     = (r_state == EXEC) & (r_done | w_clip);
    assign w_pop      = ~w_empty & ((r_state == IDLE) | w_last);
    assign w_arg_zero = (w_fifo_dout.arg == '0);

    assign load_n    = r_load_n;
    assign ce        = r_ce_q & ~w_clip;
    assign up_down   = r_up_down;
    assign data_load = r_data_load;
    assign done      = r_done | w_clip;
    assign clipped   = w_clip;
    assign busy      = (r_state == EXEC) | ~w_empty;

    // Sequencer FSM: outputs registered for the cycle that follows each edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remain    <= '0;
            r_load_n    <= 1'b1;
            r_ce_q      <= 1'b0;
            r_up_down   <= 1'b0;
            r_done      <= 1'b0;
            r_data_load <= '0;
        end else if (w_pop) begin
            // Start the head command; back-to-back with no bubble
            r_state     <= EXEC;
            r_load_n    <= 1'b1;
            r_ce_q      <= 1'b0;
            r_data_load <= '0;
            r_done      <= (w_fifo_dout.arg <= C_ONE);
            r_remain    <= w_arg_zero ? '0 : (w_fifo_dout.arg - C_ONE);
            case (w_fifo_dout.op)
                LOAD: begin
                    r_load_n    <= 1'b0;
                    r_data_load <= w_fifo_dout.arg[WIDTH-1:0];
                    r_done      <= 1'b1;
                    r_remain    <= '0;
                end
                UP, DOWN: begin
                    if (!w_arg_zero) begin
                        r_ce_q    <= 1'b1;
                        r_up_down <= (w_fifo_dout.op == UP);
                    end
                end
                default: ;
            endcase
        end else if (r_state == EXEC) begin
            if (w_last) begin
                r_state     <= IDLE;
                r_load_n    <= 1'b1;
                r_ce_q      <= 1'b0;
                r_done      <= 1'b0;
                r_data_load <= '0;
                r_remain    <= '0;
            end else begin
                r_remain    <= r_remain - C_ONE;
                r_done      <= (r_remain == C_ONE);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_cmd_sequencer
//  Description : Self-checking bench for counter_cmd_sequencer with an
//                attached WIDTH-bit up/down counter and a command-level
//                reference model (command queue + expected cycle list).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_sequencer;
    import counter_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
`ifdef CNT_SEQ_NOWRAP_EN
    localparam bit NOWRAP = 1'b1;
`else
    localparam bit NOWRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    counter_cmd_sequencer_if #(.CNT_W(CNT_W)) cmd_bus ();

    logic             max_count, zero, load_n, ce, up_down, busy, done, clipped;
    logic [WIDTH-1:0] data_load;

    counter_cmd_sequencer #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_bus.slave),
        .max_count (max_count),
        .zero      (zero),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .data_load (data_load),
        .busy      (busy),
        .done      (done),
        .clipped   (clipped)
    );

    // Counter being driven; deliberately not reset by rst_n
    logic [WIDTH-1:0] cnt = '0;
    always_ff @(posedge clk) begin
        if (!load_n)  cnt <= data_load;
        else if (ce)  cnt <= up_down ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
    end
    assign max_count = (cnt == '1);
    assign zero      = (cnt == '0);

    // ---------------- reference model ----------------
    typedef struct packed {
        op_e              op;
        logic [CNT_W-1:0] arg;
    } mcmd_t;

    typedef struct packed {
        logic             load_n;
        logic             ce;
        logic             ud_set;
        logic             ud;
        logic [WIDTH-1:0] data;
        logic             last;
    } cyc_t;

    mcmd_t            cmd_q[$];   // commands accepted but not started
    cyc_t             exp_q[$];   // remaining cycles of the running command
    mcmd_t            dir_q[$];   // directed stimulus waiting to be offered
    logic             m_ud = 1'b0;
    logic [WIDTH-1:0] m_cnt = '0;
    bit               acc = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic expand(input mcmd_t c);
        cyc_t r;
        int   n;
        n = (c.op == LOAD || c.arg == '0) ? 1 : int'(c.arg);
        for (int i = 0; i < n; i++) begin
            r        = '0;
            r.load_n = 1'b1;
            r.last   = (i == n - 1);
            if (c.op == LOAD) begin
                r.load_n = 1'b0;
                r.data   = c.arg[WIDTH-1:0];
            end else if (c.arg != '0 && (c.op == UP || c.op == DOWN)) begin
                r.ce     = 1'b1;
                r.ud_set = 1'b1;
                r.ud     = (c.op == UP);
            end
            exp_q.push_back(r);
        end
    endtask

    function automatic logic cur_clip();
        if (!NOWRAP || exp_q.size() == 0) return 1'b0;
        return exp_q[0].ce && (m_ud ? (m_cnt == '1) : (m_cnt == '0));
    endfunction

    task automatic sample_checks();
        cyc_t cur;
        logic clip;
        cur        = '0;
        cur.load_n = 1'b1;
        if (exp_q.size() != 0) cur = exp_q[0];
        clip = cur_clip();
        chk("ctl{load_n,ce,ud,done,clip,data}",
            32'({load_n, ce, up_down, done, clipped, data_load}),
            32'({cur.load_n, cur.ce & ~clip, m_ud, cur.last | clip, clip, cur.data}));
        chk("busy",  32'(busy), 32'(exp_q.size() != 0 || cmd_q.size() != 0));
        chk("ready", 32'(cmd_bus.cmd_ready), 32'(cmd_q.size() < DEPTH));
        chk("count", 32'(cnt), 32'(m_cnt));
    endtask

    task automatic drive_stim(input bit rnd);
        mcmd_t c;
        if (cmd_bus.cmd_valid && !acc) return;   // hold until accepted
        if (dir_q.size() != 0) begin
            c = dir_q.pop_front();
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_op    = c.op;
            cmd_bus.cmd_arg   = c.arg;
        end else if (rnd && $urandom_range(0, 9) < 4) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_op    = op_e'(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) cmd_bus.cmd_arg = CNT_W'($urandom_range(0, 30));
            else if (cmd_bus.cmd_op == LOAD) cmd_bus.cmd_arg = CNT_W'($urandom_range(0, 255));
            else cmd_bus.cmd_arg = CNT_W'($urandom_range(0, 4));
        end else begin
            cmd_bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic model_step();
        cyc_t  cur;
        logic  clip;
        mcmd_t c;
        acc   = cmd_bus.cmd_valid && (cmd_q.size() < DEPTH);
        c.op  = cmd_bus.cmd_op;
        c.arg = cmd_bus.cmd_arg;
        if (exp_q.size() != 0) begin
            cur  = exp_q[0];
            clip = cur_clip();
            if (!cur.load_n)          m_cnt = cur.data;
            else if (cur.ce && !clip) m_cnt = m_ud ? m_cnt + WIDTH'(1) : m_cnt - WIDTH'(1);
            if (clip) exp_q.delete();
            else      void'(exp_q.pop_front());
        end
        if (exp_q.size() == 0 && cmd_q.size() != 0) expand(cmd_q.pop_front());
        if (exp_q.size() != 0 && exp_q[0].ud_set) m_ud = exp_q[0].ud;
        if (acc) cmd_q.push_back(c);
    endtask

    task automatic cycle(input bit rnd);
        @(negedge clk);
        sample_checks();
        drive_stim(rnd);
        @(posedge clk);
        model_step();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || cmd_q.size() != 0 || dir_q.size() != 0); i++)
            cycle(1'b0);
        @(negedge clk);
        chk("drained_busy", 32'(busy), 32'(0));
    endtask

    function automatic mcmd_t mk(input op_e op, input int arg);
        mcmd_t c;
        c.op  = op;
        c.arg = CNT_W'(arg);
        return c;
    endfunction

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = LOAD;
        cmd_bus.cmd_arg   = '0;

        // Reset state
        @(negedge clk);
        chk("rst_load_n", 32'(load_n), 32'(1));
        chk("rst_ce",     32'(ce),     32'(0));
        chk("rst_ready",  32'(cmd_bus.cmd_ready), 32'(1));
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_done",   32'(done),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sequences: load+up, FIFO fill behind a long hold,
        // zero-length command, wrap/clip boundaries
        dir_q.push_back(mk(LOAD, 'hA));
        dir_q.push_back(mk(UP, 3));
        dir_q.push_back(mk(HOLD, 20));
        dir_q.push_back(mk(UP, 1));
        dir_q.push_back(mk(DOWN, 1));
        dir_q.push_back(mk(HOLD, 0));
        dir_q.push_back(mk(LOAD, 5));
        dir_q.push_back(mk(UP, 0));
        dir_q.push_back(mk(DOWN, 2));
        dir_q.push_back(mk(LOAD, 'hE));
        dir_q.push_back(mk(UP, 3));
        dir_q.push_back(mk(LOAD, 1));
        dir_q.push_back(mk(DOWN, 4));
        dir_q.push_back(mk(HOLD, 1));
        dir_q.push_back(mk(UP, 2));
        drain();

        // Asynchronous reset in the second cycle of UP 5
        dir_q.push_back(mk(UP, 5));
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        @(negedge clk);
        sample_checks();
        cmd_bus.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ce",     32'(ce),     32'(0));
        chk("async_rst_load_n", 32'(load_n), 32'(1));
        chk("async_rst_busy",   32'(busy),   32'(0));
        chk("async_rst_ready",  32'(cmd_bus.cmd_ready), 32'(1));
        exp_q.delete();
        cmd_q.delete();
        m_ud = 1'b0;
        acc  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 500; i++) cycle(1'b1);
        cmd_bus.cmd_valid = acc ? 1'b0 : cmd_bus.cmd_valid;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
